// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: encodings shared by decode, MEM/WB and the writeback register file.
//   DTR_*     writeback source select encodings
//   NOP_INST  instruction word used for pipeline bubbles
//   REG_ZERO  hardwired-zero register index
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [1:0]  DTR_ALU  = 2'b00;
    localparam logic [1:0]  DTR_MEM  = 2'b01;
    localparam logic [1:0]  DTR_LINK = 2'b10;
    localparam logic [1:0]  DTR_RSVD = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage : cpu_pkg

// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if: bundle between the pipeline (MEM/WB, ID, debug) and the
// writeback register file.
//   WB_*            MEM/WB stage bundle into the register file
//   ID_rs/rt_*      two ID-stage read ports
//   dbg_*           debug read port (array view, no bypass)
//   wb_data/wb_we   selected writeback value and effective write strobe
//   retire_count    retired non-bubble instruction count
// master = pipeline side, slave = register file.
// ---------------------------------------------------------------------------
interface wb_regfile_if #(
    parameter int DW = 32
);

    logic [DW-1:0] WB_dataout;
    logic [DW-1:0] WB_ALUout;
    logic [DW-1:0] WB_PC;
    logic [31:0]   WB_inst;
    logic [4:0]    WB_WriteAddr;
    logic          WB_RegWrite;
    logic [1:0]    WB_DataToReg;

    logic [4:0]    ID_rs_addr;
    logic [4:0]    ID_rt_addr;
    logic [DW-1:0] ID_rs_data;
    logic [DW-1:0] ID_rt_data;

    logic [4:0]    dbg_addr;
    logic [DW-1:0] dbg_data;

    logic [DW-1:0] wb_data;
    logic          wb_we;
    logic [31:0]   retire_count;

    modport master (
        output WB_dataout, WB_ALUout, WB_PC, WB_inst, WB_WriteAddr,
               WB_RegWrite, WB_DataToReg, ID_rs_addr, ID_rt_addr, dbg_addr,
        input  ID_rs_data, ID_rt_data, dbg_data, wb_data, wb_we, retire_count
    );

    modport slave (
        input  WB_dataout, WB_ALUout, WB_PC, WB_inst, WB_WriteAddr,
               WB_RegWrite, WB_DataToReg, ID_rs_addr, ID_rt_addr, dbg_addr,
        output ID_rs_data, ID_rt_data, dbg_data, wb_data, wb_we, retire_count
    );

endinterface : wb_regfile_if

// File: rtl/wb_regfile_reg_array.sv
// ---------------------------------------------------------------------------
// reg_array: NREG x DW register storage.
//   i_clk            rising-edge clock
//   i_rst            synchronous clear, active-low
//   i_we/i_waddr/i_wdata  single write port
//   i_raddr0..2 / o_rdata0..2  asynchronous read ports; index 0 reads as 0
// ---------------------------------------------------------------------------
module reg_array #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr0,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1,
    output logic [DW-1:0] o_rdata2
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // r0 is forced on the read side so a stray write can never leak out
    assign o_rdata0 = (i_raddr0 == '0) ? '0 : r_mem[i_raddr0];
    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule : reg_array

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile: writeback-side consumer of the MEM/WB register.
// Selects the writeback value, commits it to the register array, serves two
// ID read ports with same-cycle write-through bypass, and counts retired
// non-bubble instructions.
//   clk   rising-edge clock
//   rst   synchronous reset, active-low
//   bus   wb_regfile_if.slave (WB bundle, ID/debug reads, wb_data/wb_we,
//         retire_count)
// ---------------------------------------------------------------------------
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    wb_regfile_if.slave        bus
);

    logic [DW-1:0] w_wb_data;
    logic          w_wb_we;
    logic [DW-1:0] w_arr_rs;
    logic [DW-1:0] w_arr_rt;
    logic [DW-1:0] w_arr_dbg;
    logic [31:0]   r_retire_count;

    always_comb begin
        w_wb_data = bus.WB_ALUout;
        case (bus.WB_DataToReg)
            DTR_ALU:  w_wb_data = bus.WB_ALUout;
            DTR_MEM:  w_wb_data = bus.WB_dataout;
            DTR_LINK: w_wb_data = bus.WB_PC + DW'(4);
            DTR_RSVD: w_wb_data = bus.WB_ALUout;
            default:  w_wb_data = bus.WB_ALUout;
        endcase
    end

    // rst gates the strobe so a write on a reset edge is dropped and the
    // bypass stays quiet while reset is held
    assign w_wb_we = bus.WB_RegWrite & (bus.WB_WriteAddr != REG_ZERO) & rst;

    reg_array #(
        .NREG (NREG),
        .DW   (DW)
    ) u_reg_array (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_we     (w_wb_we),
        .i_waddr  (bus.WB_WriteAddr),
        .i_wdata  (w_wb_data),
        .i_raddr0 (bus.ID_rs_addr),
        .i_raddr1 (bus.ID_rt_addr),
        .i_raddr2 (bus.dbg_addr),
        .o_rdata0 (w_arr_rs),
        .o_rdata1 (w_arr_rt),
        .o_rdata2 (w_arr_dbg)
    );

    // w_wb_we already excludes r0, so a bypass can never return nonzero for r0
    assign bus.ID_rs_data = (w_wb_we && (bus.ID_rs_addr == bus.WB_WriteAddr))
                            ? w_wb_data : w_arr_rs;
    assign bus.ID_rt_data = (w_wb_we && (bus.ID_rt_addr == bus.WB_WriteAddr))
                            ? w_wb_data : w_arr_rt;
    assign bus.dbg_data   = w_arr_dbg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_retire_count <= '0;
        end else if (bus.WB_inst != NOP_INST) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign bus.wb_data      = w_wb_data;
    assign bus.wb_we        = w_wb_we;
    assign bus.retire_count = r_retire_count;

endmodule : wb_regfile

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side consumer of the MEM/WB pipeline register. It selects the writeback value from the WB-stage bundle (memory data, ALU result, or link address), commits it to a 32x32 general-purpose register file, and serves the ID stage's two combinational read ports with same-cycle write-through bypass. A retired-instruction counter and a debug read port support bring-up and verification.

## Interface
Parameters:
- `NREG`, 32, register count; r0 is hardwired to zero.
- `DW`, 32, data width.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-low
- `WB_dataout`  in  32  load data from the MEM/WB register
- `WB_ALUout`  in  32  ALU result from the MEM/WB register
- `WB_PC`  in  32  PC of the WB instruction
- `WB_inst`  in  32  WB instruction word; 0 = bubble
- `WB_WriteAddr`  in  5  destination register
- `WB_RegWrite`  in  1  write enable
- `WB_DataToReg`  in  2  writeback source select
- `ID_rs_addr`, `ID_rt_addr`  in  5 each  read addresses
- `ID_rs_data`, `ID_rt_data`  out  32 each  read data
- `dbg_addr`  in  5  debug read address
- `dbg_data`  out  32  debug read data; no bypass
- `wb_data`  out  32  selected writeback value, used for EX forwarding
- `wb_we`  out  1  effective write strobe: `WB_RegWrite & (WB_WriteAddr!=0) & rst`
- `retire_count`  out  32  count of retired non-bubble instructions

## Operation
- Source select for `wb_data`:
  - 00 = `WB_ALUout`
  - 01 = `WB_dataout`
  - 10 = `WB_PC+4` (link for jal/jalr, modulo 2^32)
  - 11 = `WB_ALUout` (reserved; aliases 00)
- Commit: on a rising edge with `wb_we`=1, `regs[WB_WriteAddr] <= wb_data`.
  - Writes to address 0 are discarded; reads of address 0 always return 0.
- Read ports are combinational. For each ID port, if `wb_we`=1 and the read address equals `WB_WriteAddr`, the output is `wb_data` (bypass). Otherwise it is the array contents.
- The debug port always returns array contents (post-commit view); address 0 returns 0.
- Retire counter: +1 on each rising edge where `rst`=1 and `WB_inst`!=0, independent of `WB_RegWrite`. Stores and branches count. Wraps from 0xFFFFFFFF to 0.

## Timing
- Write latency: the value is visible on `dbg_data` one cycle after the commit edge, and on the ID ports in the same cycle through the bypass.
- Reset, with `rst`=0 at a rising edge:
  - all `regs` are set to 0 and `retire_count` to 0;
  - any pending write that cycle is dropped.
- While `rst`=0: `wb_we`=0, so the bypass is inactive and `ID_*_data`/`dbg_data` reflect the array (0 after the first reset edge). `wb_data` still follows the mux.
- Reset mid-operation: a write presented on the same edge as reset is lost, and the counter does not increment on that edge.
- Simultaneous events:
  - The two ID ports and the debug port may all address `WB_WriteAddr` at once; both ID ports bypass and the debug port shows the old value.
  - `WB_RegWrite`=1 with `WB_WriteAddr`=0: no write, no bypass, `wb_we`=0.
- No state machine; the only sequential state is the register array and the counter. All paths are single-cycle.

## Structure
- Shared package `cpu_pkg`:
  - `DTR_ALU`=2'b00, `DTR_MEM`=2'b01, `DTR_LINK`=2'b10, `DTR_RSVD`=2'b11;
  - `NOP_INST`=32'h0;
  - `REG_ZERO`=5'd0.
  - Decode and MEM/WB already reference these encodings.
- One natural sub-module, `reg_array`: NREG x DW storage with synchronous clear, one write port, and three async read ports (r0 forced to 0).
- Select mux, bypass comparators and retire counter live in `wb_regfile`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles after random writes, then read r1..r31 on dbg -> all 0; `retire_count`=0.
- ALU write + bypass: ALUout=0x1234_5678, DataToReg=00, WriteAddr=5, RegWrite=1, `ID_rs_addr`=5:
  - `ID_rs_data`=0x12345678 the same cycle;
  - `dbg_data`(5)=0x12345678 the next cycle.
- Source select:
  - dataout=0xDEAD_BEEF, DTR=01 -> r7=0xDEADBEEF;
  - PC=0x0000_0040, DTR=10, addr 31 -> r31=0x44;
  - PC=0xFFFF_FFFC, DTR=10 -> 0x0;
  - DTR=11 with ALUout=0xA5 -> 0xA5.
- r0 protection: RegWrite=1, WriteAddr=0, ALUout=0xFFFF_FFFF -> `wb_we`=0, `ID_rs_data`(0)=0, `dbg_data`(0)=0.
- Retire counter:
  - 10 cycles alternating `WB_inst`=0x2008_0001 and 0 -> `retire_count`=5;
  - preload by running to 0xFFFF_FFFF, then one non-bubble -> 0.
- Reset collision: write r3=0x55 on the edge with `rst`=0 -> r3=0 afterwards; the counter does not increment.
